// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and state/control types for the fetch stage
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {FS_RUN = 2'd0, FS_HALT = 2'd1, FS_FAULT = 2'd2} fs_state_e;
  typedef enum logic [1:0] {IFID_HOLD = 2'd0, IFID_BUBBLE = 2'd1, IFID_CAPTURE = 2'd2} ifid_op_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus (imem address/data, redirect/stall/halt control, IF/ID and status outputs)
interface fetch_stage_if #(parameter int CNT_W = 16);
  logic [31:0] instr, redirect_pc, pc, if_id_instr, if_id_pc4;
  logic redirect, stall, halt_req, resume, if_id_valid, halted, fault;
  logic [CNT_W-1:0] fetch_count;
  modport master(output instr, redirect, redirect_pc, stall, halt_req, resume,
                 input pc, if_id_instr, if_id_pc4, if_id_valid, halted, fault, fetch_count);
  modport slave(input instr, redirect, redirect_pc, stall, halt_req, resume,
                output pc, if_id_instr, if_id_pc4, if_id_valid, halted, fault, fetch_count);
endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: next pc, next fetch state and IF/ID action from state, control inputs and range check
module next_pc_sel import mips_pkg::*; #(
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  fs_state_e   state,
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_d,
  output fs_state_e   state_d,
  output ifid_op_e    ifid_op
);
  logic misaligned, oor;
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign oor = {2'b00, pc[31:2]} >= IMEM_DEPTH;
  always_comb begin
    pc_d = pc;
    state_d = state;
    ifid_op = IFID_BUBBLE;
    case (state)
      FS_RUN:
        if (redirect) begin
          state_d = misaligned ? FS_FAULT : (halt_req ? FS_HALT : FS_RUN);
          pc_d = misaligned ? pc : redirect_pc;
        end else if (halt_req) state_d = FS_HALT;
        else if (stall) ifid_op = IFID_HOLD;
        else if (oor) state_d = FS_FAULT;
        else begin
          pc_d = pc + PC_INC;
          ifid_op = IFID_CAPTURE;
        end
      FS_HALT:
        if (redirect && misaligned) state_d = FS_FAULT;
        else begin
          pc_d = redirect ? redirect_pc : pc;
          state_d = (resume && !halt_req) ? FS_RUN : FS_HALT;
        end
      default: ;
    endcase
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch - owns pc, fills IF/ID, handles redirect/stall/halt/fault, counts fetches
//   clk, rst (async active-low); bus: instr/redirect/redirect_pc/stall/halt_req/resume in,
//   pc/if_id_instr/if_id_pc4/if_id_valid/halted/fault/fetch_count out (all registered)
module fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.slave bus
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fs_state_e state_q, state_d;
  ifid_op_e ifid_op;
  next_pc_sel #(.IMEM_DEPTH(IMEM_DEPTH)) u_sel (
    .state(state_q), .pc(pc_q), .redirect_pc(bus.redirect_pc), .redirect(bus.redirect),
    .stall(bus.stall), .halt_req(bus.halt_req), .resume(bus.resume),
    .pc_d(pc_d), .state_d(state_d), .ifid_op(ifid_op)
  );
  always_comb begin
    instr_d = ifid_op == IFID_CAPTURE ? bus.instr : ifid_op == IFID_BUBBLE ? NOP_INSTR : instr_q;
    valid_d = ifid_op == IFID_CAPTURE ? 1'b1 : ifid_op == IFID_BUBBLE ? 1'b0 : valid_q;
    pc4_d = ifid_op == IFID_CAPTURE ? pc_q + PC_INC : pc4_q;
    cnt_d = (ifid_op == IFID_CAPTURE && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      state_q <= FS_RUN;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign bus.pc = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4 = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_count = cnt_q;
  assign bus.halted = state_q == FS_HALT;
  assign bus.fault = state_q == FS_FAULT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  typedef struct {
    logic rd; logic [31:0] rpc; logic st, hr, rs;
    logic [31:0] pc, ins, pc4; logic v, h, f; logic [15:0] cnt;
  } vec_t;
  typedef struct {
    logic [31:0] pc, ins, pc4; logic v, h, f; logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  fetch_stage_if b ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(b));
  logic [31:0] mem [32];
  always_comb b.instr = (b.pc[31:7] == 25'd0) ? mem[b.pc[6:2]] : 32'h0;
  exp_t sb[$];
  vec_t ta[$], tb_[$];
  int n_vec = 0, n_err = 0;
  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic st, logic hr, logic rs,
                              logic [31:0] pc, logic [31:0] ins, logic [31:0] pc4,
                              logic v, logic h, logic f, logic [15:0] cnt);
    vec_t t;
    t.rd = rd; t.rpc = rpc; t.st = st; t.hr = hr; t.rs = rs;
    t.pc = pc; t.ins = ins; t.pc4 = pc4; t.v = v; t.h = h; t.f = f; t.cnt = cnt;
    return t;
  endfunction
  function automatic exp_t to_exp(vec_t t);
    exp_t e;
    e.pc = t.pc; e.ins = t.ins; e.pc4 = t.pc4; e.v = t.v; e.h = t.h; e.f = t.f; e.cnt = t.cnt;
    return e;
  endfunction
  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s %s got %h want %h", tag, fld, act, req);
    end
  endtask
  task automatic cmp(string tag);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk(tag, "pc", b.pc, e.pc);
    chk(tag, "if_id_instr", b.if_id_instr, e.ins);
    chk(tag, "if_id_pc4", b.if_id_pc4, e.pc4);
    chk(tag, "if_id_valid", {31'd0, b.if_id_valid}, {31'd0, e.v});
    chk(tag, "halted", {31'd0, b.halted}, {31'd0, e.h});
    chk(tag, "fault", {31'd0, b.fault}, {31'd0, e.f});
    chk(tag, "fetch_count", {16'd0, b.fetch_count}, {16'd0, e.cnt});
  endtask
  task automatic apply(vec_t t, string tag);
    b.redirect = t.rd; b.redirect_pc = t.rpc; b.stall = t.st; b.halt_req = t.hr; b.resume = t.rs;
    sb.push_back(to_exp(t));
    @(posedge clk);
    #1;
    cmp(tag);
  endtask
  task automatic expect_reset(string tag);
    sb.push_back(to_exp(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 16'd0)));
    cmp(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h00008020; mem[1] = 32'h20100007; mem[2] = 32'h00008820; mem[3] = 32'h20110001;
    b.redirect = 0; b.redirect_pc = 0; b.stall = 0; b.halt_req = 0; b.resume = 0;
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h04, 32'h00008020, 32'h04, 1, 0, 0, 1));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h08, 32'h20100007, 32'h08, 1, 0, 0, 2));
    ta.push_back(mk(0, 0,     1, 0, 0, 32'h08, 32'h20100007, 32'h08, 1, 0, 0, 2));
    ta.push_back(mk(0, 0,     1, 0, 0, 32'h08, 32'h20100007, 32'h08, 1, 0, 0, 2));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h0C, 32'h00008820, 32'h0C, 1, 0, 0, 3));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h10, 32'h20110001, 32'h10, 1, 0, 0, 4));
    ta.push_back(mk(1, 32'h10, 1, 0, 0, 32'h10, 32'h0,        32'h10, 0, 0, 0, 4));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h14, 32'h10000004, 32'h14, 1, 0, 0, 5));
    ta.push_back(mk(1, 32'h04, 0, 0, 0, 32'h04, 32'h0,       32'h14, 0, 0, 0, 5));
    ta.push_back(mk(0, 0,     0, 1, 0, 32'h04, 32'h0,        32'h14, 0, 1, 0, 5));
    ta.push_back(mk(0, 0,     1, 0, 0, 32'h04, 32'h0,        32'h14, 0, 1, 0, 5));
    ta.push_back(mk(1, 32'h1C, 0, 0, 0, 32'h1C, 32'h0,       32'h14, 0, 1, 0, 5));
    ta.push_back(mk(0, 0,     0, 0, 1, 32'h1C, 32'h0,        32'h14, 0, 0, 0, 5));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h20, 32'h10000007, 32'h20, 1, 0, 0, 6));
    ta.push_back(mk(0, 0,     0, 1, 1, 32'h20, 32'h0,        32'h20, 0, 1, 0, 6));
    ta.push_back(mk(0, 0,     0, 1, 1, 32'h20, 32'h0,        32'h20, 0, 1, 0, 6));
    ta.push_back(mk(0, 0,     0, 0, 1, 32'h20, 32'h0,        32'h20, 0, 0, 0, 6));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h24, 32'h10000008, 32'h24, 1, 0, 0, 7));
    ta.push_back(mk(1, 32'h78, 0, 1, 0, 32'h78, 32'h0,       32'h24, 0, 1, 0, 7));
    ta.push_back(mk(0, 0,     0, 0, 1, 32'h78, 32'h0,        32'h24, 0, 0, 0, 7));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h7C, 32'h1000001E, 32'h7C, 1, 0, 0, 8));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h80, 32'h1000001F, 32'h80, 1, 0, 0, 9));
    ta.push_back(mk(0, 0,     0, 0, 0, 32'h80, 32'h0,        32'h80, 0, 0, 1, 9));
    ta.push_back(mk(1, 32'h0, 0, 0, 1, 32'h80, 32'h0,        32'h80, 0, 0, 1, 9));
    tb_.push_back(mk(0, 0,     0, 0, 0, 32'h04, 32'h00008020, 32'h04, 1, 0, 0, 1));
    tb_.push_back(mk(1, 32'h06, 0, 0, 0, 32'h04, 32'h0,       32'h04, 0, 0, 1, 1));
    tb_.push_back(mk(1, 32'h08, 1, 0, 1, 32'h04, 32'h0,       32'h04, 0, 0, 1, 1));
    #12;
    expect_reset("reset");
    @(negedge clk) rst = 1'b1;
    foreach (ta[i]) apply(ta[i], $sformatf("seq_a[%0d]", i));
    #2 rst = 1'b0;
    #1 expect_reset("async_reset");
    @(negedge clk) rst = 1'b1;
    foreach (tb_[i]) apply(tb_[i], $sformatf("seq_b[%0d]", i));
    @(negedge clk) rst = 1'b0;
    #1 expect_reset("fault_clear");
    @(posedge clk);
    #1 expect_reset("held_in_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core: owns the program counter and drives `pc` into the 32-word combinational instruction memory.
- Captures the returned `instr` into an IF/ID pipeline register for the decoder.
- Handles sequential advance, branch/jump redirect, stall, halt/resume and fetch faults (misaligned target, PC beyond memory depth).
- Keeps a saturating fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 32, number of 32-bit words in instruction memory; valid word index is 0..IMEM_DEPTH-1.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word read combinationally from memory at `pc`.
- redirect  in  1  taken branch or jump this cycle.
- redirect_pc  in  32  redirect target byte address.
- stall  in  1  hazard stall from decode; hold PC and IF/ID.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  32  current fetch address to instruction memory.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered pc+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT (sticky until reset).
- fetch_count  out  CNT_W  number of valid instructions captured; saturates.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC; if_id_instr = 32'h0 (NOP); if_id_pc4 = 0; if_id_valid = 0; fetch_count = 0; state = RUN.
  - Entering reset mid-operation discards everything; first capture occurs on the first rising edge after rst rises.
- FSM states: RUN, HALT, FAULT (2-bit encoding). `halted` and `fault` are decoded from the state.
- `pc` is a register output. `instr` is valid in the same cycle; capture latency is 1 cycle (edge after `pc` is presented).
- Word index = pc[31:2]. Out of range when index >= IMEM_DEPTH.
- RUN, evaluated each edge in priority order:
  1. redirect=1:
     - If redirect_pc[1:0] != 0: go to FAULT, pc holds, IF/ID becomes a bubble.
     - Otherwise: pc <= redirect_pc; IF/ID flushed (instr=0, valid=0, pc4 unchanged).
     - Redirect overrides stall.
     - If halt_req is also 1, the redirect is applied and state goes to HALT.
  2. halt_req=1: state goes to HALT; pc holds; IF/ID becomes a bubble.
  3. stall=1: pc, if_id_*, and fetch_count all hold.
  4. Current index out of range: go to FAULT; IF/ID becomes a bubble.
  5. Normal advance:
     - pc <= pc+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 0, but out-of-range triggers first).
     - if_id_instr <= instr; if_id_pc4 <= pc+4; if_id_valid <= 1.
     - fetch_count increments unless already all-ones.
- HALT:
  - IF/ID holds a bubble; pc holds; stall is ignored.
  - redirect with an aligned target updates pc and stays in HALT; a misaligned target goes to FAULT.
  - resume=1 returns to RUN with no capture that cycle; the first capture happens on the following edge.
  - resume and halt_req both 1: stay in HALT.
- FAULT: terminal until reset. pc frozen; IF/ID bubble; all inputs ignored.
- A bubble always means if_id_instr = 32'h0 and if_id_valid = 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package `mips_pkg`:
  - NOP_INSTR = 32'h0.
  - State enum/localparams FS_RUN=2'd0, FS_HALT=2'd1, FS_FAULT=2'd2.
  - PC_INC = 32'd4.
- One natural combinational sub-module, `next_pc_sel`: computes next pc and the fault condition from the state, redirect, stall, halt_req and range check.
- Registers stay in `fetch_stage`.

Test Plan:
- Memory words 0..3 = 00008020, 20100007, 00008820, 20110001; release reset → pc steps 0,4,8,C; if_id_instr follows one cycle later with valid=1; fetch_count=4 after 4 captures.
- stall=1 for 2 cycles while pc=8 → pc stays 8, if_id_instr stays 20100007, count unchanged; then resumes at 8.
- redirect=1 with redirect_pc=0x10 while stall=1 → next cycle pc=0x10, if_id_valid=0, if_id_instr=0; following cycle captures word 4.
- halt_req at pc=4 → halted=1, bubbles, pc=4 held; redirect to 0x1C during HALT → pc=0x1C; resume → next edge captures word 7.
- redirect_pc=0x0000_0006 → fault=1, pc frozen, valid=0; later redirects ignored; rst low clears fault and pc=0.
- Run sequentially to pc=0x80 (index 32) → fault=1 at that edge; assert rst asynchronously mid-cycle → all outputs reach reset values before the next clk edge.
